// File: rtl/conv_strip_scheduler_pkg.sv
// Shared state encoding and default geometry for the strip scheduler and its result FIFO.
package conv_strip_scheduler_pkg;

    localparam int STRIP_COLS = 224;
    localparam int STRIP_ROWS = 30;
    localparam int KERNEL_DIM = 3;

    // Valid-convolution output count of one strip: (cols-2) x (rows-2) for a 3x3 kernel.
    function automatic int conv_out_count(input int cols, input int rows, input int k);
        return (cols - k + 1) * (rows - k + 1);
    endfunction

    localparam int DEF_OUT_PER_STRIP = conv_out_count(STRIP_COLS, STRIP_ROWS, KERNEL_DIM);
    localparam int DEF_DATA_W        = 23;
    localparam int DEF_ADDR_W        = 13;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_DONE = 3'd3,
        DRAIN     = 3'd4,
        FINISH    = 3'd5,
        ERROR     = 3'd6
    } sched_state_t;

endpackage

// File: rtl/conv_result_fifo.sv
// Small synchronous FIFO with occupancy count; head is read combinationally and holds until popped.
module conv_result_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is cleared on reset so the result outputs read zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/conv_strip_scheduler.sv
// Frame controller: resets/launches all strip units, waits for done, then drains results in strip order.
// Optional watchdog in WAIT_DONE is compiled in with `define SCHED_TIMEOUT_EN.
module conv_strip_scheduler
    import conv_strip_scheduler_pkg::*;
#(
    parameter int NUM_STRIPS    = 8,
    parameter int OUT_PER_STRIP = DEF_OUT_PER_STRIP,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int RD_LAT        = 2,
    parameter int TIMEOUT       = 1048576
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_start,
    input  logic                           kernel_read_complete,
    input  logic [NUM_STRIPS-1:0]          strip_done,
    input  logic [NUM_STRIPS*DATA_W-1:0]   strip_out,
    output logic                           strip_rst,
    output logic                           strip_start,
    output logic [ADDR_W-1:0]              strip_addr,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic [$clog2(NUM_STRIPS)-1:0]  out_strip,
    output logic                           out_last,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           timeout_err,
    output logic [2:0]                     state_dbg
);

    localparam int SEL_W  = $clog2(NUM_STRIPS);
    localparam int FIFO_D = RD_LAT + 1;
    localparam int CNT_W  = $clog2(FIFO_D + 1);
    localparam int FIFO_W = 1 + SEL_W + DATA_W;
    localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(NUM_STRIPS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_PER_STRIP - 1);

    sched_state_t      state_q, state_d;
    logic              clear_cnt_q;
    logic [SEL_W-1:0]  sel_q, next_sel;
    logic [ADDR_W-1:0] next_addr;
    logic              next_last, issue, first_issue, room, all_issued, pop;
    logic [RD_LAT-1:0] pipe_vld_q, pipe_last_q;
    logic [SEL_W-1:0]  pipe_sel_q [RD_LAT];
    logic [FIFO_W-1:0] push_data, head;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] sampled;

    // Result stream: a beat transfers on a cycle with out_valid && out_ready; while out_valid is
    // high and out_ready low the beat (data, strip, last) is held and out_valid never drops.
    assign pop        = out_valid && out_ready;
    assign all_issued = (sel_q == LAST_SEL) && (strip_addr == LAST_ADDR);
    // Reserve a FIFO slot per read in flight; a pop this cycle frees one, keeping full rate.
    assign room       = (int'(fifo_count) + $countones(pipe_vld_q)) < (FIFO_D + int'(pop));
    assign busy       = (state_q != IDLE);
    assign state_dbg  = state_q;

`ifdef SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt_q;
    logic            wd_hit;

    assign wd_hit      = (wd_cnt_q == WD_W'(TIMEOUT - 1));
    assign timeout_err = (state_q == ERROR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    wd_cnt_q <= '0;
        else if (state_q == WAIT_DONE) wd_cnt_q <= wd_cnt_q + 1'b1;
        else                          wd_cnt_q <= '0;
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        first_issue = 1'b0;
        strip_rst   = 1'b0;
        strip_start = 1'b0;
        frame_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_start && kernel_read_complete) state_d = CLEAR;
            end
            CLEAR: begin
                strip_rst = 1'b1;
                if (clear_cnt_q) state_d = LAUNCH;
            end
            LAUNCH: begin
                strip_start = 1'b1;
                state_d     = WAIT_DONE;
            end
            WAIT_DONE: begin
                strip_start = 1'b1;
                if (&strip_done) begin
                    state_d     = DRAIN;
                    issue       = 1'b1;
                    first_issue = 1'b1;
                end
`ifdef SCHED_TIMEOUT_EN
                else if (wd_hit) begin
                    state_d = ERROR;
                end
`endif
            end
            DRAIN: begin
                issue = room && !all_issued;
                if (pop && out_last) state_d = FINISH;
            end
            FINISH: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
`ifdef SCHED_TIMEOUT_EN
            ERROR: begin
                state_d = ERROR;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Position of the read being issued; strip_addr/sel_q always hold the last issued position.
    always_comb begin
        next_sel  = sel_q;
        next_addr = strip_addr;
        if (first_issue) begin
            next_sel  = '0;
            next_addr = '0;
        end else if (strip_addr == LAST_ADDR) begin
            next_sel  = sel_q + 1'b1;
            next_addr = '0;
        end else begin
            next_addr = strip_addr + 1'b1;
        end
        next_last = (next_sel == LAST_SEL) && (next_addr == LAST_ADDR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clear_cnt_q <= 1'b0;
            sel_q       <= '0;
            strip_addr  <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_sel_q[i] <= '0;
        end else begin
            clear_cnt_q <= (state_q == CLEAR) ? !clear_cnt_q : 1'b0;
            if (issue) begin
                sel_q      <= next_sel;
                strip_addr <= next_addr;
            end
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue && next_last;
            pipe_sel_q[0]  <= next_sel;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
                pipe_sel_q[i]  <= pipe_sel_q[i-1];
            end
        end
    end

    // Read data is captured RD_LAT edges after the address changed, tagged with its issuing strip.
    assign sampled   = strip_out[int'(pipe_sel_q[RD_LAT-1]) * DATA_W +: DATA_W];
    assign push_data = {pipe_last_q[RD_LAT-1], pipe_sel_q[RD_LAT-1], sampled};

    conv_result_fifo #(
        .DEPTH (FIFO_D),
        .WIDTH (FIFO_W),
        .CNT_W (CNT_W)
    ) u_result_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pipe_vld_q[RD_LAT-1]),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid                      = !fifo_empty;
    assign {out_last, out_strip, out_data} = head;

endmodule
